// File: rtl/amm_mem_slave.sv
// Avalon-MM memory responder: one pipelined read port and one byte-enabled write
// port onto a shared word array, with forced or LFSR-driven waitrequest insertion.
module amm_mem_slave #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BYTE_CNT     = DATA_WIDTH / 8,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RAND_WAIT    = 0,
  parameter logic [15:0] RD_SEED      = 16'hACE1,
  parameter logic [15:0] WR_SEED      = 16'h1D2B
) (
  input  logic                  clk_i,
  input  logic                  srst_n_i,
  input  logic                  rd_stall_i,
  input  logic                  wr_stall_i,
  input  logic [ADDR_WIDTH-1:0] amm_rd_address_i,
  input  logic                  amm_rd_read_i,
  output logic [DATA_WIDTH-1:0] amm_rd_readdata_o,
  output logic                  amm_rd_readdatavalid_o,
  output logic                  amm_rd_waitrequest_o,
  input  logic [ADDR_WIDTH-1:0] amm_wr_address_i,
  input  logic                  amm_wr_write_i,
  input  logic [DATA_WIDTH-1:0] amm_wr_writedata_i,
  input  logic [BYTE_CNT-1:0]   amm_wr_byteenable_i,
  output logic                  amm_wr_waitrequest_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW    = READ_LATENCY * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                                     ready_q;
  logic [15:0]                              rd_lfsr;
  logic [15:0]                              wr_lfsr;
  logic                                     rd_acc;
  logic                                     wr_acc;
  logic [READ_LATENCY-1:0]                  vld_q;
  logic [READ_LATENCY-1:0]                  vld_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  dat_q;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0]  dat_d;
  logic [DATA_WIDTH-1:0]                    be_mask;

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_comb begin
    amm_rd_waitrequest_o = !ready_q | rd_stall_i |
                           ((RAND_WAIT != 0) & (rd_lfsr[1:0] == 2'b00));
    amm_wr_waitrequest_o = !ready_q | wr_stall_i |
                           ((RAND_WAIT != 0) & (wr_lfsr[1:0] == 2'b00));
    rd_acc = srst_n_i & amm_rd_read_i & !amm_rd_waitrequest_o;
    wr_acc = srst_n_i & amm_wr_write_i & !amm_wr_waitrequest_o;
  end

  always_comb begin
    be_mask = '0;
    for (int unsigned i = 0; i < BYTE_CNT; i++) begin
      be_mask[8*i +: 8] = {8{amm_wr_byteenable_i[i]}};
    end
  end

  // Data shifts freely behind the valid bits; only the output stage holds its
  // value so readdata keeps the last returned word between strobes.
  always_comb begin
    vld_d = READ_LATENCY'({vld_q, rd_acc});
    dat_d = PW'({dat_q, mem[amm_rd_address_i]});
    if (!vld_d[READ_LATENCY-1]) begin
      dat_d[READ_LATENCY-1] = dat_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      ready_q  <= 1'b0;
      rd_lfsr  <= RD_SEED;
      wr_lfsr  <= WR_SEED;
      vld_q    <= '0;
      dat_q    <= '0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      ready_q <= 1'b1;
      rd_lfsr <= lfsr_step(rd_lfsr);
      wr_lfsr <= lfsr_step(wr_lfsr);
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      if (rd_acc) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (wr_acc) wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end

  // Array is deliberately outside reset so accepted writes survive a reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[amm_wr_address_i] <= (mem[amm_wr_address_i] & ~be_mask) |
                               (amm_wr_writedata_i & be_mask);
    end
  end

  always_comb begin
    amm_rd_readdatavalid_o = vld_q[READ_LATENCY-1];
    amm_rd_readdata_o      = dat_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_amm_mem_slave.sv
// Scoreboard bench for amm_mem_slave: directed vectors on a fixed-wait instance and
// a read-back sweep on an LFSR-wait instance.
module tb_amm_mem_slave;
  localparam int RL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n = 1'b0, rd_stall = 1'b0, wr_stall = 1'b0;
  logic [9:0]  rd_addr = '0, wr_addr = '0;
  logic        rd_read = 1'b0, wr_write = 1'b0;
  logic [63:0] rd_data, wr_data = '0;
  logic [7:0]  wr_be = '0;
  logic        rd_valid, rd_wait, wr_wait;
  logic [31:0] rd_cnt, wr_cnt;

  logic        r_rst_n = 1'b0;
  logic [9:0]  r_rd_addr = '0, r_wr_addr = '0;
  logic        r_rd_read = 1'b0, r_wr_write = 1'b0;
  logic [63:0] r_rd_data, r_wr_data = '0;
  logic [7:0]  r_wr_be = '0;
  logic        r_rd_valid, r_rd_wait, r_wr_wait;
  logic [31:0] r_rd_cnt, r_wr_cnt;

  amm_mem_slave #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .READ_LATENCY(RL)) dut (
    .clk_i(clk), .srst_n_i(rst_n), .rd_stall_i(rd_stall), .wr_stall_i(wr_stall),
    .amm_rd_address_i(rd_addr), .amm_rd_read_i(rd_read), .amm_rd_readdata_o(rd_data),
    .amm_rd_readdatavalid_o(rd_valid), .amm_rd_waitrequest_o(rd_wait),
    .amm_wr_address_i(wr_addr), .amm_wr_write_i(wr_write), .amm_wr_writedata_i(wr_data),
    .amm_wr_byteenable_i(wr_be), .amm_wr_waitrequest_o(wr_wait),
    .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt));

  amm_mem_slave #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .READ_LATENCY(RL), .RAND_WAIT(1)) dut_r (
    .clk_i(clk), .srst_n_i(r_rst_n), .rd_stall_i(1'b0), .wr_stall_i(1'b0),
    .amm_rd_address_i(r_rd_addr), .amm_rd_read_i(r_rd_read), .amm_rd_readdata_o(r_rd_data),
    .amm_rd_readdatavalid_o(r_rd_valid), .amm_rd_waitrequest_o(r_rd_wait),
    .amm_wr_address_i(r_wr_addr), .amm_wr_write_i(r_wr_write), .amm_wr_writedata_i(r_wr_data),
    .amm_wr_byteenable_i(r_wr_be), .amm_wr_waitrequest_o(r_wr_wait),
    .rd_cnt_o(r_rd_cnt), .wr_cnt_o(r_wr_cnt));

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t q[$];
  exp_t q2[$];

  logic        ready_m = 1'b0;
  logic [31:0] rcnt_m = '0, wcnt_m = '0;
  logic [63:0] hold_m = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pat(input int a);
    return {32'hC0DE_0000 + 32'(a), 32'(a * 3)};
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (rd_valid === 1'b1) begin
        if (q.size() == 0) check("rd_unexpected_valid", rd_valid, 1'b0);
        else begin
          e = q.pop_front();
          check("rd_data", rd_data, e.data);
          check("rd_latency", 64'(cyc), 64'(e.due));
          hold_m = e.data;
        end
      end else begin
        check("rd_hold", rd_data, hold_m);
      end
    end
  end

  always @(negedge clk) begin : mon_r
    exp_t e;
    if (r_rd_valid === 1'b1) begin
      if (q2.size() == 0) check("r_rd_unexpected_valid", r_rd_valid, 1'b0);
      else begin
        e = q2.pop_front();
        check("r_rd_data", r_rd_data, e.data);
        check("r_rd_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic step(input logic r, input logic [9:0] ra, input logic [63:0] rexp,
                      input logic w, input logic [9:0] wa, input logic [63:0] wd,
                      input logic [7:0] be, input logic rs, input logic ws, input logic rn);
    @(posedge clk); #1;
    rst_n = rn; rd_read = r; rd_addr = ra; rd_stall = rs;
    wr_write = w; wr_addr = wa; wr_data = wd; wr_be = be; wr_stall = ws;
    @(negedge clk);
    check("rd_waitrequest", rd_wait, !ready_m | rs);
    check("wr_waitrequest", wr_wait, !ready_m | ws);
    check("rd_cnt", rd_cnt, rcnt_m);
    check("wr_cnt", wr_cnt, wcnt_m);
    #1;
    if (rn && r && ready_m && !rs) begin
      q.push_back(exp_t'{rexp, cyc + RL});
      rcnt_m++;
    end
    if (rn && w && ready_m && !ws) wcnt_m++;
    if (!rn) begin
      q.delete();
      rcnt_m = '0;
      wcnt_m = '0;
      hold_m = '0;
    end
    ready_m = rn;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic wr(input logic [9:0] a, input logic [63:0] d, input logic [7:0] be);
    step(0, 0, 0, 1, a, d, be, 0, 0, 1);
  endtask
  task automatic rd(input logic [9:0] a, input logic [63:0] e);
    step(1, a, e, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int ra;
    int stalls;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    idle();
    wr(5, 64'h0011223344556677, 8'hFF);
    rd(5, 64'h0011223344556677);
    repeat (3) idle();
    wr(7, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(7, 64'h0, 8'h0F);
    rd(7, 64'hFFFFFFFF00000000);
    wr(7, 64'h1234, 8'h00);
    rd(7, 64'hFFFFFFFF00000000);
    for (int i = 0; i < 4; i++) wr(10'(i), 64'(10 + i), 8'hFF);
    rd(0, 64'd10); rd(1, 64'd11); rd(2, 64'd12); rd(3, 64'd13);
    repeat (3) idle();
    repeat (3) step(1, 5, 64'h0011223344556677, 0, 0, 0, 0, 1, 0, 1);
    rd(5, 64'h0011223344556677);
    repeat (2) step(0, 0, 0, 1, 6, 64'hBEEF, 8'hFF, 0, 1, 1);
    wr(6, 64'hBEEF, 8'hFF);
    rd(6, 64'hBEEF);
    wr(9, 64'hA, 8'hFF);
    step(1, 9, 64'hA, 1, 9, 64'hB, 8'hFF, 0, 0, 1);
    rd(9, 64'hB);
    repeat (3) idle();
    wr(20, 64'h55, 8'hFF);
    rd(9, 64'hB);
    step(1, 9, 64'hB, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idle();
    rd(20, 64'h55);
    rd(5, 64'h0011223344556677);
    repeat (4) idle();
    check("drain", 64'(q.size()), 64'd0);

    @(posedge clk); #1 r_rst_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) begin
      r_wr_write = 1'b1; r_wr_addr = 10'(a); r_wr_data = pat(a); r_wr_be = 8'hFF;
      k = 0;
      @(negedge clk);
      while (r_wr_wait !== 1'b0 && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("r_wr_accept_timeout", k < 50, 1'b1);
      @(posedge clk); #1;
    end
    r_wr_write = 1'b0;
    r_rd_read = 1'b1;
    ra = 0;
    stalls = 0;
    for (int n = 0; n < 1000; n++) begin
      r_rd_addr = 10'(ra);
      @(negedge clk);
      if (r_rd_wait) stalls++;
      else begin
        q2.push_back(exp_t'{pat(ra), cyc + RL});
        ra = (ra + 1) % 16;
      end
      @(posedge clk); #1;
    end
    r_rd_read = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("r_drain", 64'(q2.size()), 64'd0);
    check("r_rd_cnt", r_rd_cnt, 32'(1000 - stalls));
    check("r_wr_cnt", r_wr_cnt, 32'd16);
    check("r_stall_ratio", (stalls >= 200 && stalls <= 300), 1'b1);
    $display("random phase stalls=%0d of 1000", stalls);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
